// File: rtl/rs_pkg.sv
// Shared reservation-station definitions: payload field macros, default tag width
// and the scheduler slot record.
`ifndef RS_PKG_DEFS
`define RS_PKG_DEFS
`define RS_WIDTH  106
`define RS_OP     105:99
`define RS_FUNCT3 98:96
`define RS_DATA1  95:64
`define RS_DATA2  63:32
`define RS_IMM    31:0
`endif

package rs_pkg;

    localparam int unsigned RS_W      = `RS_WIDTH;
    localparam int unsigned TAG_W_DEF = 6;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W_DEF-1:0] s1_tag;
        logic                 s1_rdy;
        logic [TAG_W_DEF-1:0] s2_tag;
        logic                 s2_rdy;
        logic [RS_W-1:0]      payload;
    } sched_slot_t;

endpackage

// File: rtl/rs_age_pick.sv
// Age-matrix selector: oldest eligible slot and the oldest of the remainder, both one-hot.
// age[i][j]=1 means slot i is older than slot j.
module rs_age_pick #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0][N-1:0] age,
    input  logic [N-1:0]        elig,
    output logic [N-1:0]        oldest,
    output logic [N-1:0]        second
);

    // A slot wins when no other candidate in the mask is older than it.
    function automatic logic [N-1:0] pick_oldest(input logic [N-1:0][N-1:0] a,
                                                 input logic [N-1:0]        m);
        logic [N-1:0] r;
        logic         beaten;
        r = '0;
        for (int unsigned i = 0; i < N; i++) begin
            beaten = 1'b0;
            for (int unsigned j = 0; j < N; j++)
                if (m[j] && a[j][i])
                    beaten = 1'b1;
            r[i] = m[i] && !beaten;
        end
        return r;
    endfunction

    assign oldest = pick_oldest(age, elig);
    assign second = pick_oldest(age, elig & ~oldest);

endmodule

// File: rtl/rs_issue_sched.sv
// Dual-ALU issue scheduler: holds RS entries, wakes sources from CDB tags, issues oldest-first.
// Optional RS_WAKEUP_BYPASS_EN lets a same-cycle CDB match feed straight into select.
module rs_issue_sched
    import rs_pkg::*;
#(
    parameter int unsigned ENTRIES   = 8,
    parameter int unsigned TAG_W     = TAG_W_DEF,
    parameter int unsigned PAYLOAD_W = `RS_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      disp_valid,
    output logic                      disp_ready,
    input  logic [PAYLOAD_W-1:0]      disp_payload,
    input  logic [TAG_W-1:0]          disp_s1_tag,
    input  logic                      disp_s1_rdy,
    input  logic [TAG_W-1:0]          disp_s2_tag,
    input  logic                      disp_s2_rdy,
    input  logic                      cdb_valid,
    input  logic [TAG_W-1:0]          cdb_tag,
    output logic                      alu1_valid,
    input  logic                      alu1_ready,
    output logic [PAYLOAD_W-1:0]      alu1_rs,
    output logic                      alu2_valid,
    input  logic                      alu2_ready,
    output logic [PAYLOAD_W-1:0]      alu2_rs,
    output logic [$clog2(ENTRIES):0]  occupancy
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned OCC_W = IDX_W + 1;

    logic [ENTRIES-1:0]              slot_valid, s1_rdy, s2_rdy;
    logic [TAG_W-1:0]                s1_tag  [ENTRIES];
    logic [TAG_W-1:0]                s2_tag  [ENTRIES];
    logic [PAYLOAD_W-1:0]            payload [ENTRIES];
    logic [ENTRIES-1:0][ENTRIES-1:0] age, age_nxt;

    logic [ENTRIES-1:0] hit1, hit2, elig, first_oh, second_oh, pick1, pick2, freed;
    logic [IDX_W-1:0]   free_idx;
    logic [PAYLOAD_W-1:0] sel1, sel2;
    logic load1, load2, accept;

    always_comb begin
        hit1 = '0;
        hit2 = '0;
        elig = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            hit1[i] = cdb_valid && (cdb_tag == s1_tag[i]);
            hit2[i] = cdb_valid && (cdb_tag == s2_tag[i]);
`ifdef RS_WAKEUP_BYPASS_EN
            elig[i] = slot_valid[i] && (s1_rdy[i] || hit1[i]) && (s2_rdy[i] || hit2[i]);
`else
            elig[i] = slot_valid[i] && s1_rdy[i] && s2_rdy[i];
`endif
        end
    end

    always_comb begin
        free_idx = '0;
        for (int unsigned i = ENTRIES; i > 0; i--)
            if (!slot_valid[i-1])
                free_idx = IDX_W'(i - 1);
    end

    rs_age_pick #(.N(ENTRIES)) u_pick (
        .age    (age),
        .elig   (elig),
        .oldest (first_oh),
        .second (second_oh)
    );

    // When alu1 cannot take a new entry, alu2 gets the oldest instead of the runner-up.
    assign load1      = !alu1_valid || alu1_ready;
    assign load2      = !alu2_valid || alu2_ready;
    assign pick1      = load1 ? first_oh : '0;
    assign pick2      = !load2 ? '0 : (load1 ? second_oh : first_oh);
    assign freed      = pick1 | pick2;
    assign disp_ready = occupancy < OCC_W'(ENTRIES);
    assign accept     = disp_valid && disp_ready;

    always_comb begin
        sel1 = '0;
        sel2 = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (pick1[i]) sel1 = sel1 | payload[i];
            if (pick2[i]) sel2 = sel2 | payload[i];
        end
    end

    // Freed slots drop out of the order; a new slot is younger than every survivor.
    always_comb begin
        for (int unsigned i = 0; i < ENTRIES; i++)
            for (int unsigned j = 0; j < ENTRIES; j++)
                age_nxt[i][j] = age[i][j] && !freed[i] && !freed[j];
        if (accept) begin
            for (int unsigned j = 0; j < ENTRIES; j++) begin
                age_nxt[free_idx][j] = 1'b0;
                age_nxt[j][free_idx] = slot_valid[j] && !freed[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_valid <= '0;
            age        <= '0;
            alu1_valid <= 1'b0;
            alu2_valid <= 1'b0;
            alu1_rs    <= '0;
            alu2_rs    <= '0;
            occupancy  <= '0;
        end else if (flush) begin
            slot_valid <= '0;
            age        <= '0;
            alu1_valid <= 1'b0;
            alu2_valid <= 1'b0;
            occupancy  <= '0;
        end else begin
            age       <= age_nxt;
            occupancy <= occupancy + OCC_W'(accept) - OCC_W'(|pick1) - OCC_W'(|pick2);
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                if (hit1[i])  s1_rdy[i]     <= 1'b1;
                if (hit2[i])  s2_rdy[i]     <= 1'b1;
                if (freed[i]) slot_valid[i] <= 1'b0;
            end
            if (accept) begin
                slot_valid[free_idx] <= 1'b1;
                s1_tag[free_idx]     <= disp_s1_tag;
                s2_tag[free_idx]     <= disp_s2_tag;
                s1_rdy[free_idx]     <= disp_s1_rdy || (cdb_valid && cdb_tag == disp_s1_tag);
                s2_rdy[free_idx]     <= disp_s2_rdy || (cdb_valid && cdb_tag == disp_s2_tag);
                payload[free_idx]    <= disp_payload;
            end
            if (load1) begin
                alu1_valid <= |pick1;
                if (|pick1) alu1_rs <= sel1;
            end
            if (load2) begin
                alu2_valid <= |pick2;
                if (|pick2) alu2_rs <= sel2;
            end
        end
    end

endmodule

// File: tb/tb_rs_issue_sched.sv
// Directed bench for rs_issue_sched against an age-ordered queue model; honours RS_WAKEUP_BYPASS_EN.
module tb_rs_issue_sched;
    import rs_pkg::*;

    localparam int unsigned ENT = 8;
    localparam int unsigned TW  = TAG_W_DEF;
    localparam int unsigned PW  = RS_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, flush, disp_valid, disp_s1_rdy, disp_s2_rdy, cdb_valid;
    logic          alu1_ready, alu2_ready;
    logic [PW-1:0] disp_payload;
    logic [TW-1:0] disp_s1_tag, disp_s2_tag, cdb_tag;
    logic          disp_ready, alu1_valid, alu2_valid;
    logic [PW-1:0] alu1_rs, alu2_rs;
    logic [$clog2(ENT):0] occupancy;

    rs_issue_sched #(.ENTRIES(ENT), .TAG_W(TW), .PAYLOAD_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_payload(disp_payload),
        .disp_s1_tag(disp_s1_tag), .disp_s1_rdy(disp_s1_rdy),
        .disp_s2_tag(disp_s2_tag), .disp_s2_rdy(disp_s2_rdy),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .alu1_valid(alu1_valid), .alu1_ready(alu1_ready), .alu1_rs(alu1_rs),
        .alu2_valid(alu2_valid), .alu2_ready(alu2_ready), .alu2_rs(alu2_rs),
        .occupancy(occupancy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] mk(input int n);
        logic [PW-1:0] p;
        p = '0;
        p[PW-1 -: 8] = 8'hA5;
        p[31:0]      = 32'h100 + 32'(n);
        return p;
    endfunction

    // Model: slots kept oldest-first in a queue; issue registers tracked separately.
    sched_slot_t   mq[$];
    sched_slot_t   ms, ns;
    logic          m_v1, m_v2;
    logic [PW-1:0] m_rs1, m_rs2;
    int            el[$];
    int            p1, p2;
    bit            acc, ld1, ld2, w1, w2;

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_v1 = 1'b0; m_v2 = 1'b0; m_rs1 = '0; m_rs2 = '0;
        end else if (flush) begin
            mq.delete();
            m_v1 = 1'b0; m_v2 = 1'b0;
        end else begin
            acc = disp_valid && (mq.size() < ENT);
            el.delete();
            for (int i = 0; i < mq.size(); i++) begin
                ms = mq[i];
                w1 = ms.s1_rdy || (cdb_valid && cdb_tag == ms.s1_tag);
                w2 = ms.s2_rdy || (cdb_valid && cdb_tag == ms.s2_tag);
`ifdef RS_WAKEUP_BYPASS_EN
                if (w1 && w2) el.push_back(i);
`else
                if (ms.s1_rdy && ms.s2_rdy) el.push_back(i);
`endif
                ms.s1_rdy = w1;
                ms.s2_rdy = w2;
                mq[i] = ms;
            end
            ld1 = !m_v1 || alu1_ready;
            ld2 = !m_v2 || alu2_ready;
            p1 = -1;
            p2 = -1;
            if (ld1 && el.size() > 0) p1 = el[0];
            if (ld2 && el.size() > (ld1 ? 1 : 0)) p2 = ld1 ? el[1] : el[0];
            if (ld1) begin
                m_v1 = (p1 >= 0);
                if (p1 >= 0) m_rs1 = mq[p1].payload;
            end
            if (ld2) begin
                m_v2 = (p2 >= 0);
                if (p2 >= 0) m_rs2 = mq[p2].payload;
            end
            if (p2 >= 0) mq.delete(p2);
            if (p1 >= 0) mq.delete(p1);
            if (acc) begin
                ns.valid   = 1'b1;
                ns.s1_tag  = disp_s1_tag;
                ns.s2_tag  = disp_s2_tag;
                ns.s1_rdy  = disp_s1_rdy || (cdb_valid && cdb_tag == disp_s1_tag);
                ns.s2_rdy  = disp_s2_rdy || (cdb_valid && cdb_tag == disp_s2_tag);
                ns.payload = disp_payload;
                mq.push_back(ns);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("occupancy", 128'(occupancy), 128'(mq.size()));
            check("disp_ready", 128'(disp_ready), 128'(mq.size() < ENT));
            check("alu1_valid", 128'(alu1_valid), 128'(m_v1));
            check("alu2_valid", 128'(alu2_valid), 128'(m_v2));
            if (m_v1) check("alu1_rs", 128'(alu1_rs), 128'(m_rs1));
            if (m_v2) check("alu2_rs", 128'(alu2_rs), 128'(m_rs2));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input int n, input bit r1, input logic [TW-1:0] t1,
                        input bit r2, input logic [TW-1:0] t2);
        disp_valid   = 1'b1;
        disp_payload = mk(n);
        disp_s1_rdy  = r1;
        disp_s1_tag  = t1;
        disp_s2_rdy  = r2;
        disp_s2_tag  = t2;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; cdb_valid = 1'b0; cdb_tag = '0;
        alu1_ready = 1'b1; alu2_ready = 1'b1;
        disp(99, 1, 0, 1, 0);
        tick(); tick();
        rst_n = 1'b1;
        idle();
        chk_en = 1'b1;
        check("rst_occ", 128'(occupancy), 128'(0));
        check("rst_disp_ready", 128'(disp_ready), 128'(1));
        check("rst_alu1_valid", 128'(alu1_valid), 128'(0));
        check("rst_alu2_valid", 128'(alu2_valid), 128'(0));
        check("rst_alu1_rs", 128'(alu1_rs), 128'(0));
        check("rst_alu2_rs", 128'(alu2_rs), 128'(0));

        // 1: single ready entry, two-cycle latency
        disp(1, 1, 0, 1, 0);
        tick(); idle();
        check("t1_occ_after_disp", 128'(occupancy), 128'(1));
        check("t1_alu1_not_yet", 128'(alu1_valid), 128'(0));
        tick();
        check("t1_alu1_valid", 128'(alu1_valid), 128'(1));
        check("t1_alu1_rs", 128'(alu1_rs), 128'(mk(1)));
        check("t1_occ_drained", 128'(occupancy), 128'(0));
        tick();
        check("t1_alu1_empty", 128'(alu1_valid), 128'(0));

        // 2: younger ready entry bypasses an older waiting one
        disp(2, 0, 5, 1, 0); tick();
        disp(3, 1, 0, 1, 0); tick();
        idle(); tick();
        check("t2_b_first", 128'(alu1_rs), 128'(mk(3)));
        cdb_valid = 1'b1; cdb_tag = 6'd5;
        tick();
        cdb_valid = 1'b0;
`ifdef RS_WAKEUP_BYPASS_EN
        check("t2_a_wake_1cyc", 128'(alu1_rs), 128'(mk(2)));
        check("t2_a_valid_1cyc", 128'(alu1_valid), 128'(1));
`else
        check("t2_a_not_yet", 128'(alu1_valid), 128'(0));
        tick();
        check("t2_a_wake_2cyc", 128'(alu1_rs), 128'(mk(2)));
        check("t2_a_valid_2cyc", 128'(alu1_valid), 128'(1));
`endif
        tick(); tick();

        // 3: fill to capacity with both ALUs stalled, then drain in pairs
        alu1_ready = 1'b0; alu2_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            disp(10 + k, 1, 0, 1, 0);
            tick();
        end
        check("t3_occ6", 128'(occupancy), 128'(6));
        for (int k = 8; k < 10; k++) begin
            disp(10 + k, 1, 0, 1, 0);
            tick();
        end
        check("t3_occ8", 128'(occupancy), 128'(8));
        check("t3_full", 128'(disp_ready), 128'(0));
        disp(20, 1, 0, 1, 0);
        tick(); idle();
        check("t3_drop_when_full", 128'(occupancy), 128'(8));
        check("t3_alu1_held", 128'(alu1_rs), 128'(mk(10)));
        check("t3_alu2_held", 128'(alu2_rs), 128'(mk(11)));
        alu1_ready = 1'b1; alu2_ready = 1'b1;
        tick();
        check("t3_pair_alu1", 128'(alu1_rs), 128'(mk(12)));
        check("t3_pair_alu2", 128'(alu2_rs), 128'(mk(13)));
        check("t3_occ_after_pair", 128'(occupancy), 128'(6));
        repeat (5) tick();

        // 4: dispatch and wakeup of the same tag in one cycle
        disp(30, 1, 0, 0, 9);
        cdb_valid = 1'b1; cdb_tag = 6'd9;
        tick();
        idle(); cdb_valid = 1'b0;
        tick();
        check("t4_same_cycle_wake", 128'(alu1_rs), 128'(mk(30)));
        check("t4_valid", 128'(alu1_valid), 128'(1));
        tick();

        // 5: alu2 stalls while alu1 keeps draining
        alu1_ready = 1'b0; alu2_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            disp(40 + k, 1, 0, 1, 0);
            tick();
        end
        idle();
        alu1_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t5_alu2_hold_valid", 128'(alu2_valid), 128'(1));
            check("t5_alu2_hold_rs", 128'(alu2_rs), 128'(mk(41)));
        end
        check("t5_alu1_drained", 128'(alu1_valid), 128'(0));
        alu2_ready = 1'b1;
        tick();
        check("t5_alu2_released", 128'(alu2_valid), 128'(0));

        // 6: flush with occupancy 5 and both issue registers full
        alu1_ready = 1'b0; alu2_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            disp(50 + k, 1, 0, 1, 0);
            tick();
        end
        check("t6_occ5", 128'(occupancy), 128'(5));
        check("t6_both_valid", 128'({alu1_valid, alu2_valid}), 128'(2'b11));
        flush = 1'b1;
        disp(60, 1, 0, 1, 0);
        tick();
        flush = 1'b0; idle();
        check("t6_flush_occ", 128'(occupancy), 128'(0));
        check("t6_flush_valids", 128'({alu1_valid, alu2_valid}), 128'(2'b00));
        check("t6_flush_ready", 128'(disp_ready), 128'(1));
        alu1_ready = 1'b1; alu2_ready = 1'b1;
        tick();
        check("t6_dropped_disp", 128'(alu1_valid), 128'(0));

        // 7: reset mid-operation discards a held issue
        alu1_ready = 1'b0;
        disp(70, 1, 0, 1, 0);
        tick(); idle(); tick();
        check("t7_held_before_rst", 128'(alu1_rs), 128'(mk(70)));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t7_rst_valid", 128'(alu1_valid), 128'(0));
        check("t7_rst_rs", 128'(alu1_rs), 128'(0));
        check("t7_rst_occ", 128'(occupancy), 128'(0));
        alu1_ready = 1'b1;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
